// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the loader FSM state type.
// Also used by the instruction memory and the fetch stage.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 32;
  localparam int unsigned IMEM_AW    = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: streams host words into instruction memory from word 0 and
// keeps the core stalled until a complete load has been written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] len,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  output logic               s_ready,
  output logic               mem_we,
  output logic [31:0]        mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               core_stall,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [IMEM_AW-1:0] DepthW = IMEM_AW'(DEPTH);

  loader_state_e      state_q, state_d;
  logic [IMEM_AW-1:0] cnt_q, cnt_d;
  logic [IMEM_AW-1:0] len_q, len_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               stall_q, stall_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic len_ok;
  logic hs;

  assign len_ok  = (len != '0) && (len <= DepthW);
  assign s_ready = (state_q == LOAD);
  assign hs      = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    stall_d = stall_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            cnt_d   = '0;
            err_d   = 1'b0;
            stall_d = 1'b1;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = s_data;
          cnt_d   = cnt_q + IMEM_AW'(1);
          if (cnt_q == len_q - IMEM_AW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // Final write is on the port this cycle; release the core once it lands.
      DRAIN: begin
        state_d = IDLE;
        stall_d = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      stall_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_waddr  = {{(32 - IMEM_AW - 2){1'b0}}, waddr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign core_stall = stall_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a words-remaining model predicts every
// output each cycle, and a captured memory image is checked after each load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  len = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, mem_we, core_stall, busy, done, err;
  logic [31:0] mem_waddr, mem_wdata;

  imem_loader #(.DEPTH(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .core_stall (core_stall),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: words still owed by the host plus a one-cycle drain flag.
  int          m_left = 0;
  int          m_idx = 0;
  bit          m_drain = 1'b0;
  logic        e_we = 1'b0, e_stall = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_data = '0;

  logic [31:0] tb_mem [32];
  logic [31:0] exp_words [32];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = '0;

  logic [31:0] prog [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; m_idx = 0; m_drain = 1'b0;
        e_we = 1'b0; e_addr = '0; e_data = '0;
        e_stall = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end else begin
        e_we = 1'b0;
        e_done = 1'b0;
        if (m_drain) begin
          m_drain = 1'b0;
          e_done = 1'b1;
          e_stall = 1'b0;
        end else if (m_left > 0) begin
          if (s_valid) begin
            e_we = 1'b1;
            e_addr = 32'(m_idx * 4);
            e_data = s_data;
            m_idx++;
            m_left--;
            if (m_left == 0) m_drain = 1'b1;
          end
        end else if (start) begin
          if (len >= 1 && len <= 32) begin
            m_left = int'(len);
            m_idx = 0;
            e_err = 1'b0;
            e_stall = 1'b1;
          end else begin
            e_err = 1'b1;
          end
        end
        e_busy = (m_left > 0) || m_drain;
      end
    end
  end

  // Compare and capture on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready", s_ready, (m_left > 0));
      chk("mem_we", mem_we, e_we);
      chk("mem_waddr", mem_waddr, e_addr);
      chk("mem_wdata", mem_wdata, e_data);
      chk("core_stall", core_stall, e_stall);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (rst_n && mem_we) begin
        tb_mem[mem_waddr[6:2]] = mem_wdata;
        wr_cnt++;
        last_addr = mem_waddr;
      end
      if (rst_n && done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = 6'(l);
    cyc(1);
    start = 1'b0;
    len = 6'($urandom);
  endtask

  task automatic send(input logic [31:0] word, input int gaps, input bit noise);
    int n;
    for (int g = 0; g < gaps; g++) begin
      s_valid = 1'b0;
      s_data = $urandom;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len = 6'($urandom);
      end
      cyc(1);
    end
    start = 1'b0;
    s_valid = 1'b1;
    s_data = word;
    n = 0;
    while (!s_ready && n < 20) begin
      cyc(1);
      n++;
    end
    if (n == 20) chk("s_ready_wait", s_ready, 1);
    cyc(1);
    s_valid = 1'b0;
    s_data = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 10) begin
      cyc(1);
      n++;
    end
    chk("done_seen", done, 1);
    cyc(1);
  endtask

  task automatic load(input int l, input int maxgap, input bit noise);
    do_start(l);
    for (int i = 0; i < l; i++) begin
      exp_words[i] = $urandom;
      send(exp_words[i], $urandom_range(0, maxgap), noise);
    end
    wait_done();
    for (int i = 0; i < l; i++) chk("mem_image", tb_mem[i], exp_words[i]);
  endtask

  int w0, d0;

  initial begin
    prog[0] = 32'h00500093; prog[1] = 32'h00A08113; prog[2] = 32'h002081B3;
    prog[3] = 32'h00208263; prog[4] = 32'h01400213; prog[5] = 32'h01E00293;

    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("idle_stall", core_stall, 1);
    chk("idle_ready", s_ready, 0);
    chk("idle_writes", wr_cnt, 0);
    chk("idle_done", done_cnt, 0);

    // Back-to-back six-word program.
    w0 = wr_cnt; d0 = done_cnt;
    do_start(6);
    for (int i = 0; i < 6; i++) send(prog[i], 0, 1'b0);
    wait_done();
    chk("t2_writes", wr_cnt - w0, 6);
    chk("t2_last_addr", last_addr, 32'h14);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_stall_low", core_stall, 0);
    for (int i = 0; i < 6; i++) chk("t2_mem", tb_mem[i], prog[i]);

    // Valid pattern 1,0,0,1,0,1.
    w0 = wr_cnt;
    do_start(3);
    send(32'hA0, 0, 1'b0);
    send(32'hA1, 2, 1'b0);
    send(32'hA2, 1, 1'b0);
    wait_done();
    chk("t3_writes", wr_cnt - w0, 3);
    chk("t3_last_addr", last_addr, 32'h8);
    chk("t3_mem2", tb_mem[2], 32'hA2);

    // Illegal lengths, then a legal start clears err.
    w0 = wr_cnt;
    do_start(0);
    chk("t4_err_len0", err, 1);
    do_start(33);
    chk("t4_err_len33", err, 1);
    chk("t4_busy", busy, 0);
    cyc(2);
    chk("t4_no_writes", wr_cnt - w0, 0);
    do_start(2);
    chk("t4_err_clear", err, 0);
    send(32'h11, 0, 1'b0);
    send(32'h22, 1, 1'b0);
    wait_done();

    // Full-depth load.
    w0 = wr_cnt; d0 = done_cnt;
    load(32, 2, 1'b1);
    cyc(3);
    chk("t5_writes", wr_cnt - w0, 32);
    chk("t5_last_addr", last_addr, 32'h7C);
    chk("t5_done_pulses", done_cnt - d0, 1);

    // Asynchronous reset after two of five words.
    do_start(5);
    send(32'hDEAD0000, 0, 1'b0);
    send(32'hDEAD0001, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", core_stall, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_ready", s_ready, 0);
    chk("t6_rst_addr", mem_waddr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    w0 = wr_cnt;
    load(5, 1, 1'b0);
    chk("t6_writes", wr_cnt - w0, 5);
    chk("t6_last_addr", last_addr, 32'h10);

    repeat (6) load($urandom_range(1, 32), 3, 1'b1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
